hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 255, meaning the number of consecutive memory-stall cycles after which wdog_err_o is raised.
REQ-002 SHALL have ports (name, direction, width, meaning):
  - clk_i  in  1: single system clock, rising edge.
  - rst_ni  in  1: asynchronous, active-low reset.
  - id_rs1_i, id_rs2_i  in  5: ID-stage source register indices.
  - id_rs1_en_i, id_rs2_en_i  in  1: source register is actually read.
  - ex_rd_i  in  5: EX-stage destination register.
  - ex_mem_read_i  in  1: EX-stage instruction is a load.
  - ex_redirect_i  in  1: EX resolved a taken branch or jump (PC redirect).
  - ex_busy_i  in  1: multi-cycle EX unit (MUL/DIV) not done.
  - mem_stall_i  in  1: data memory wait.
  - pc_mode_o, if_id_mode_o, id_ex_mode_o, ex_mem_mode_o, mem_wb_mode_o  out  2: per-register mode (Normal/Stall/Flush).
  - stall_cnt_o  out  16: saturating count of cycles with pc_mode_o = Stall.
  - wdog_err_o  out  1: sticky memory-stall timeout.

Function
REQ-003 SHALL encode modes as Normal = 2'b00, Stall = 2'b01, Flush = 2'b10; 2'b11 SHALL never be driven.
REQ-004 SHALL detect load-use when ex_mem_read_i=1, ex_rd_i≠0, and (id_rs1_en_i and id_rs1_i=ex_rd_i) or (id_rs2_en_i and id_rs2_i=ex_rd_i).
REQ-005 SHALL produce mode outputs combinationally from the current inputs and the FSM state, with zero-cycle latency.
REQ-006 Priority (highest first) SHALL be mem_stall_i, then redirect, then ex_busy_i, then load-use.
REQ-007 mem_stall_i=1: all five modes SHALL be Stall.
REQ-008 Redirect:
  - Applies when ex_redirect_i=1, or when redirect_pend=1, and mem_stall_i=0.
  - pc_mode_o SHALL be Normal; if_id_mode_o and id_ex_mode_o SHALL be Flush; the rest SHALL be Normal.
REQ-009 If ex_redirect_i=1 while mem_stall_i=1, SHALL set the redirect_pend register; the flush of REQ-008 SHALL then occur in the first cycle with mem_stall_i=0, and redirect_pend SHALL clear on that edge.
REQ-010 ex_busy_i=1 (no higher-priority event):
  - pc, if_id, and id_ex modes SHALL be Stall.
  - ex_mem_mode_o SHALL be Flush (bubble).
  - mem_wb_mode_o SHALL be Normal.
REQ-011 Load-use (no higher-priority event):
  - pc and if_id modes SHALL be Stall.
  - id_ex_mode_o SHALL be Flush.
  - The rest SHALL be Normal.
  - Exactly one bubble per load-use: the FSM SHALL suppress load-use detection in the cycle immediately following.
REQ-012 FSM states and transitions:
  - RUN -> LDUSE on load-use.
  - LDUSE -> RUN unconditionally after one cycle, unless mem_stall_i=1, which holds LDUSE.
  - RUN/LDUSE -> BUSY on ex_busy_i; BUSY -> RUN when ex_busy_i=0.
  - Redirect in any state -> RUN.
REQ-013 With no events, all modes SHALL be Normal.
REQ-014 stall_cnt_o SHALL increment on every cycle where pc_mode_o=Stall and SHALL saturate at 16'hFFFF without wrapping.
REQ-015 Watchdog:
  - An internal 8-bit (or wider, per WDOG_LIMIT) counter SHALL count consecutive mem_stall_i cycles and clear when mem_stall_i=0.
  - wdog_err_o SHALL set when the counter reaches WDOG_LIMIT and SHALL stay set until reset.
REQ-016 The same mode logic SHALL apply in every state; only the load-use suppression (REQ-011) and redirect_pend (REQ-009) depend on state.

Reset
REQ-017 On rst_ni=0, asynchronously:
  - FSM SHALL go to RUN.
  - redirect_pend, stall_cnt_o, the watchdog counter, and wdog_err_o SHALL go to 0.
REQ-018 During reset, all mode outputs SHALL read Normal.
REQ-019 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; the first post-reset cycle SHALL behave as RUN.

Structure
REQ-020 Mode encodings (Normal/Stall/Flush) and the register-index width SHALL live in the shared global defines header, used by all pipeline registers.
REQ-021 SHALL be a single module, except for one natural sub-module, hazard_ldu_detect (combinational load-use compare).
REQ-022 FSM state encoding SHALL be local (2 bits: RUN, LDUSE, BUSY).

Verification
REQ-023 Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_rs1_en_i=1 -> one cycle of pc=Stall, if_id=Stall, id_ex=Flush; next cycle all Normal; stall_cnt_o=1.
REQ-024 ex_rd_i=0 with a matching rs1 -> no stall, all Normal.
REQ-025 Redirect during mem stall: ex_redirect_i=1 together with mem_stall_i=1 for 3 cycles -> 3 cycles all Stall, then 1 cycle if_id=Flush and id_ex=Flush, then Normal.
REQ-026 ex_busy_i high for 4 cycles -> 4 cycles of pc/if_id/id_ex=Stall and ex_mem=Flush; stall_cnt_o=4.
REQ-027 Redirect and load-use in the same cycle -> flush pattern only, no Stall.
REQ-028 Watchdog: mem_stall_i held for 255 cycles with WDOG_LIMIT=255 -> wdog_err_o=1 on the 255th edge and still 1 after mem_stall_i drops; rst_ni pulse -> 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline-register mode encodings and index width
package hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_STALL  = 2'b01,
        MODE_FLUSH  = 2'b10
    } mode_e;

    typedef struct packed {
        mode_e pc;
        mode_e if_id;
        mode_e id_ex;
        mode_e ex_mem;
        mode_e mem_wb;
    } modes_t;

    // Saturating 16-bit increment used by the stall statistics counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_ldu_detect.sv
// rtl/hazard_ldu_detect.sv - combinational load-use dependency compare
module hazard_ldu_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_en_i,
    input  logic                 id_rs2_en_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 ldu_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a real dependency, so a load targeting it cannot hazard
    always_comb begin
        rs1_hit = id_rs1_en_i && (id_rs1_i == ex_rd_i);
        rs2_hit = id_rs2_en_i && (id_rs2_i == ex_rd_i);
        ldu_o   = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller producing per-register stall/flush modes
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_en_i,
    input  logic                 id_rs2_en_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_redirect_i,
    input  logic                 ex_busy_i,
    input  logic                 mem_stall_i,
    output logic [1:0]           pc_mode_o,
    output logic [1:0]           if_id_mode_o,
    output logic [1:0]           id_ex_mode_o,
    output logic [1:0]           ex_mem_mode_o,
    output logic [1:0]           mem_wb_mode_o,
    output logic [15:0]          stall_cnt_o,
    output logic                 wdog_err_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LDUSE = 2'b01,
        ST_BUSY  = 2'b10
    } state_e;

    localparam int unsigned WCNT_RAW = $clog2(WDOG_LIMIT + 1);
    localparam int unsigned WCNT_W   = (WCNT_RAW > 8) ? WCNT_RAW : 8;
    localparam logic [WCNT_W-1:0] WDOG_MAX = WCNT_W'(WDOG_LIMIT);

    state_e             state_q, state_d;
    logic               redirect_pend_q, redirect_pend_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic [WCNT_W-1:0]  wdog_cnt_q, wdog_cnt_d;
    logic               wdog_err_q, wdog_err_d;

    logic   ldu_hit;
    logic   ldu_eff;
    logic   redirect_now;
    modes_t modes;

    hazard_ldu_detect u_ldu_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_en_i   (id_rs1_en_i),
        .id_rs2_en_i   (id_rs2_en_i),
        .ex_rd_i       (ex_rd_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ldu_o         (ldu_hit)
    );

    // Mode selection by event priority; outputs forced Normal while reset is held
    always_comb begin
        redirect_now = ex_redirect_i || redirect_pend_q;
        ldu_eff      = ldu_hit && (state_q != ST_LDUSE);
        modes.pc     = MODE_NORMAL;
        modes.if_id  = MODE_NORMAL;
        modes.id_ex  = MODE_NORMAL;
        modes.ex_mem = MODE_NORMAL;
        modes.mem_wb = MODE_NORMAL;
        if (!rst_ni) begin
            modes.pc = MODE_NORMAL;
        end else if (mem_stall_i) begin
            modes.pc     = MODE_STALL;
            modes.if_id  = MODE_STALL;
            modes.id_ex  = MODE_STALL;
            modes.ex_mem = MODE_STALL;
            modes.mem_wb = MODE_STALL;
        end else if (redirect_now) begin
            modes.if_id = MODE_FLUSH;
            modes.id_ex = MODE_FLUSH;
        end else if (ex_busy_i) begin
            modes.pc     = MODE_STALL;
            modes.if_id  = MODE_STALL;
            modes.id_ex  = MODE_STALL;
            modes.ex_mem = MODE_FLUSH;
        end else if (ldu_eff) begin
            modes.pc    = MODE_STALL;
            modes.if_id = MODE_STALL;
            modes.id_ex = MODE_FLUSH;
        end
    end

    // Next-state: a memory stall freezes the FSM; LDUSE exists only to mask one repeat detection
    always_comb begin
        state_d = state_q;
        if (mem_stall_i) begin
            state_d = state_q;
        end else if (redirect_now) begin
            state_d = ST_RUN;
        end else if (ex_busy_i) begin
            state_d = ST_BUSY;
        end else if (ldu_eff) begin
            state_d = ST_LDUSE;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Redirect pending capture, stall statistics and memory-stall watchdog
    always_comb begin
        redirect_pend_d = mem_stall_i ? (redirect_pend_q || ex_redirect_i) : 1'b0;
        stall_cnt_d     = (modes.pc == MODE_STALL) ? sat_inc16(stall_cnt_q) : stall_cnt_q;
        if (!mem_stall_i) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q >= WDOG_MAX) begin
            wdog_cnt_d = wdog_cnt_q;
        end else begin
            wdog_cnt_d = wdog_cnt_q + WCNT_W'(1);
        end
        wdog_err_d = wdog_err_q || (mem_stall_i && (wdog_cnt_d == WDOG_MAX));
    end

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_RUN;
            redirect_pend_q <= 1'b0;
            stall_cnt_q     <= '0;
            wdog_cnt_q      <= '0;
            wdog_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            stall_cnt_q     <= stall_cnt_d;
            wdog_cnt_q      <= wdog_cnt_d;
            wdog_err_q      <= wdog_err_d;
        end
    end

    assign pc_mode_o     = modes.pc;
    assign if_id_mode_o  = modes.if_id;
    assign id_ex_mode_o  = modes.id_ex;
    assign ex_mem_mode_o = modes.ex_mem;
    assign mem_wb_mode_o = modes.mem_wb;
    assign stall_cnt_o   = stall_cnt_q;
    assign wdog_err_o    = wdog_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl with behavioural model
module tb_hazard_ctrl;

    localparam int LIMIT = 255;
    // Packed {pc, if_id, id_ex, ex_mem, mem_wb} patterns
    localparam logic [9:0] P_NORMAL = 10'b00_00_00_00_00;
    localparam logic [9:0] P_MEMSTL = 10'b01_01_01_01_01;
    localparam logic [9:0] P_REDIR  = 10'b00_10_10_00_00;
    localparam logic [9:0] P_BUSY   = 10'b01_01_01_10_00;
    localparam logic [9:0] P_LDU    = 10'b01_01_10_00_00;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic       id_rs1_en_i = 1'b0, id_rs2_en_i = 1'b0;
    logic       ex_mem_read_i = 1'b0, ex_redirect_i = 1'b0, ex_busy_i = 1'b0, mem_stall_i = 1'b0;
    logic [1:0] pc_mode_o, if_id_mode_o, id_ex_mode_o, ex_mem_mode_o, mem_wb_mode_o;
    logic [15:0] stall_cnt_o;
    logic       wdog_err_o;
    logic [9:0] dut_modes;

    int n_vec = 0;
    int n_fail = 0;

    // Model state: pending redirect, what the last non-memory-stalled cycle did, counters
    bit m_pend;
    bit m_last_was_ldu;
    int m_scnt;
    int m_wcnt;
    bit m_werr;

    hazard_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_en_i   (id_rs1_en_i),
        .id_rs2_en_i   (id_rs2_en_i),
        .ex_rd_i       (ex_rd_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_redirect_i (ex_redirect_i),
        .ex_busy_i     (ex_busy_i),
        .mem_stall_i   (mem_stall_i),
        .pc_mode_o     (pc_mode_o),
        .if_id_mode_o  (if_id_mode_o),
        .id_ex_mode_o  (id_ex_mode_o),
        .ex_mem_mode_o (ex_mem_mode_o),
        .mem_wb_mode_o (mem_wb_mode_o),
        .stall_cnt_o   (stall_cnt_o),
        .wdog_err_o    (wdog_err_o)
    );

    assign dut_modes = {pc_mode_o, if_id_mode_o, id_ex_mode_o, ex_mem_mode_o, mem_wb_mode_o};

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit load_use_seen();
        bit dep1, dep2;
        dep1 = id_rs1_en_i && (id_rs1_i == ex_rd_i);
        dep2 = id_rs2_en_i && (id_rs2_i == ex_rd_i);
        return ex_mem_read_i && (ex_rd_i != 0) && (dep1 || dep2);
    endfunction

    function automatic logic [9:0] model_modes();
        if (!rst_ni)                       return P_NORMAL;
        if (mem_stall_i)                   return P_MEMSTL;
        if (ex_redirect_i || m_pend)       return P_REDIR;
        if (ex_busy_i)                     return P_BUSY;
        if (load_use_seen() && !m_last_was_ldu) return P_LDU;
        return P_NORMAL;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_last_was_ldu = 0; m_scnt = 0; m_wcnt = 0; m_werr = 0;
    endtask

    // Compare DUT against the model mid-cycle, away from the clock edge
    task automatic sample();
        @(negedge clk_i);
        if (!rst_ni) model_reset();
        chk("modes", 32'(dut_modes), 32'(model_modes()));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_scnt));
        chk("wdog_err", 32'(wdog_err_o), 32'(m_werr));
    endtask

    // Apply the clock-edge consequences of the current cycle to the model, then move past the edge
    task automatic advance();
        logic [9:0] m;
        m = model_modes();
        if (!rst_ni) begin
            model_reset();
        end else begin
            if (m[9:8] == 2'b01 && m_scnt < 65535) m_scnt++;
            if (mem_stall_i) begin
                m_pend = m_pend || ex_redirect_i;
                if (m_wcnt < LIMIT) m_wcnt++;
                if (m_wcnt == LIMIT) m_werr = 1;
            end else begin
                m_wcnt = 0;
                m_pend = 0;
                m_last_was_ldu = (m == P_LDU);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1_i = 0; id_rs2_i = 0; ex_rd_i = 0;
        id_rs1_en_i = 0; id_rs2_en_i = 0;
        ex_mem_read_i = 0; ex_redirect_i = 0; ex_busy_i = 0; mem_stall_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        idle_inputs();
        sample();
        advance();
        rst_ni = 1;
    endtask

    initial begin
        int ms_left;
        model_reset();
        idle_inputs();
        #2;
        sample();
        chk("reset_modes_normal", 32'(dut_modes), 32'(P_NORMAL));
        chk("reset_stall_cnt", 32'(stall_cnt_o), 0);
        advance();
        rst_ni = 1;

        // x0 destination never hazards
        ex_mem_read_i = 1; ex_rd_i = 0; id_rs1_i = 0; id_rs1_en_i = 1;
        sample();
        chk("rd0_no_stall", 32'(dut_modes), 32'(P_NORMAL));
        advance();

        // Single load-use bubble, masked the cycle after even with identical inputs
        do_reset();
        ex_mem_read_i = 1; ex_rd_i = 5; id_rs1_i = 5; id_rs1_en_i = 1;
        sample();
        chk("ldu_bubble", 32'(dut_modes), 32'(P_LDU));
        advance();
        sample();
        chk("ldu_suppressed", 32'(dut_modes), 32'(P_NORMAL));
        chk("ldu_stall_cnt", 32'(stall_cnt_o), 1);
        advance();
        idle_inputs();

        // Redirect arriving during a memory stall is replayed after it
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ex_redirect_i = 1; mem_stall_i = 1;
            sample();
            chk("redir_memstall", 32'(dut_modes), 32'(P_MEMSTL));
            advance();
        end
        idle_inputs();
        sample();
        chk("redir_replayed", 32'(dut_modes), 32'(P_REDIR));
        advance();
        sample();
        chk("redir_done", 32'(dut_modes), 32'(P_NORMAL));
        chk("redir_stall_cnt", 32'(stall_cnt_o), 3);
        advance();

        // Multi-cycle EX unit
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ex_busy_i = 1;
            sample();
            chk("busy_pattern", 32'(dut_modes), 32'(P_BUSY));
            advance();
        end
        idle_inputs();
        sample();
        chk("busy_done", 32'(dut_modes), 32'(P_NORMAL));
        chk("busy_stall_cnt", 32'(stall_cnt_o), 4);
        advance();

        // Redirect beats load-use
        do_reset();
        ex_redirect_i = 1; ex_mem_read_i = 1; ex_rd_i = 5; id_rs1_i = 5; id_rs1_en_i = 1;
        sample();
        chk("redir_over_ldu", 32'(dut_modes), 32'(P_REDIR));
        advance();
        idle_inputs();

        // Watchdog fires on the LIMIT-th edge and is sticky until reset
        do_reset();
        mem_stall_i = 1;
        for (int i = 0; i < LIMIT; i++) begin
            sample();
            if (i == LIMIT - 1) chk("wdog_before_limit", 32'(wdog_err_o), 0);
            advance();
        end
        sample();
        chk("wdog_at_limit", 32'(wdog_err_o), 1);
        advance();
        mem_stall_i = 0;
        sample();
        chk("wdog_sticky", 32'(wdog_err_o), 1);
        advance();
        do_reset();
        sample();
        chk("wdog_cleared", 32'(wdog_err_o), 0);
        advance();

        // Randomized traffic with occasional mid-flight resets
        ms_left = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_ni = ($urandom_range(0, 149) != 0);
            id_rs1_i = 5'($urandom_range(0, 3));
            id_rs2_i = 5'($urandom_range(0, 3));
            ex_rd_i  = 5'($urandom_range(0, 3));
            id_rs1_en_i = 1'($urandom_range(0, 1));
            id_rs2_en_i = 1'($urandom_range(0, 1));
            ex_mem_read_i = 1'($urandom_range(0, 1));
            ex_redirect_i = ($urandom_range(0, 9) == 0);
            ex_busy_i = ($urandom_range(0, 6) == 0);
            if (ms_left == 0 && $urandom_range(0, 7) == 0) ms_left = $urandom_range(1, 6);
            mem_stall_i = (ms_left != 0);
            if (ms_left != 0) ms_left--;
            sample();
            advance();
        end

        rst_ni = 1;
        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

endmodule
